// File: rtl/ternary_pkg.sv
// Shared balanced-ternary types and helpers.
//   trit_t      : one trit, 2-bit code (T_ZERO=00, T_POS=01, T_NEG=11; 10 reads as zero)
//   trit9_t     : one 9-trit instruction word
//   TRIT9_ZERO  : all-zero instruction word
//   trit_add()  : single-trit full adder, returns {carry, sum}
package ternary_pkg;

    typedef logic [1:0] trit_t;
    typedef trit_t [8:0] trit9_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b11;

    localparam trit9_t TRIT9_ZERO = {9{T_ZERO}};

    function automatic int trit_val(input trit_t t);
        case (t)
            T_POS:   return 1;
            T_NEG:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic trit_t val_trit(input int v);
        if (v > 0)
            return T_POS;
        else if (v < 0)
            return T_NEG;
        else
            return T_ZERO;
    endfunction

    // Sum of three trits lies in -3..3; fold it back into one digit plus carry.
    function automatic logic [3:0] trit_add(input trit_t a, input trit_t b, input trit_t cin);
        int s;
        s = trit_val(a) + trit_val(b) + trit_val(cin);
        if (s > 1)
            return {T_POS, val_trit(s - 3)};
        else if (s < -1)
            return {T_NEG, val_trit(s + 3)};
        else
            return {T_ZERO, val_trit(s)};
    endfunction

endpackage

// File: rtl/ternary_pc_incr.sv
// Balanced-ternary PC incrementer.
//   pc      : current PC (PC_TRITS trits)
//   inc     : increment 0, 1 or 2 (3 is treated as 0)
//   pc_next : pc + inc modulo 3^PC_TRITS; the carry out of the top trit is dropped,
//             so the largest positive value plus one wraps to the most negative.
module ternary_pc_incr
    import ternary_pkg::*;
#(
    parameter int PC_TRITS = 8
) (
    input  trit_t [PC_TRITS-1:0] pc,
    input  logic  [1:0]          inc,
    output trit_t [PC_TRITS-1:0] pc_next
);

    trit_t [PC_TRITS-1:0] addend;

    // +2 in balanced ternary is 1T (3 - 1).
    always_comb begin
        addend = {PC_TRITS{T_ZERO}};
        case (inc)
            2'd1: addend[0] = T_POS;
            2'd2: begin
                addend[0] = T_NEG;
                addend[1] = T_POS;
            end
            default: ;
        endcase
    end

    always_comb begin
        trit_t      carry;
        logic [3:0] r;
        carry   = T_ZERO;
        r       = '0;
        pc_next = {PC_TRITS{T_ZERO}};
        for (int i = 0; i < PC_TRITS; i++) begin
            r          = trit_add(pc[i], addend[i], carry);
            pc_next[i] = r[1:0];
            carry      = r[3:2];
        end
    end

endmodule

// File: rtl/ternary_fetch_queue.sv
// Dual-issue instruction fetch queue for a balanced-ternary core.
// Fetches up to two instructions per cycle from a combinational-read IMEM into a
// circular buffer and presents the two oldest entries to issue.
//   clk, rst        : clock; synchronous active-high reset
//   fetch_en        : allows pushes this cycle
//   redirect_valid  : flush queue and load redirect_pc into the fetch PC
//   imem_addr       : fetch PC; imem_data returns instr at PC ([8:0]) and PC+1 ([17:9])
//   deq_count       : instructions consumed by issue (3 treated as 2)
//   out_valid/out_instr/out_pc : head and head+1 view; occupancy : valid entries
// Build option: TERNARY_FETCH_BYPASS_EN forwards imem_data straight to the outputs
// while the queue is empty; bypassed instructions consumed in the same cycle are
// never written into the buffer.
module ternary_fetch_queue
    import ternary_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_TRITS    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fetch_en,
    input  logic                             redirect_valid,
    input  trit_t [PC_TRITS-1:0]             redirect_pc,
    output trit_t [PC_TRITS-1:0]             imem_addr,
    input  trit_t [17:0]                     imem_data,
    input  logic  [1:0]                      deq_count,
    output logic  [1:0]                      out_valid,
    output trit_t [17:0]                     out_instr,
    output trit_t [PC_TRITS-1:0]             out_pc,
    output logic  [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef trit_t [PC_TRITS-1:0] pc_t;

    pc_t              fetch_pc;
    pc_t              pc_adv;
    pc_t              fetch_pc_p1;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ;

    trit9_t mem_instr [QUEUE_DEPTH];
    pc_t    mem_pc    [QUEUE_DEPTH];

    logic [1:0]       deq_eff;
    logic [1:0]       pop_n;
    logic [1:0]       push_n;
    logic [1:0]       wr_n;
    logic [1:0]       src_ofs;
    logic             bypass;
    int               free;
    logic [OCC_W-1:0] occ_next;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;

    // k is at most 2 and depth at least 2, so one wrap subtraction is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= QUEUE_DEPTH)
            s -= QUEUE_DEPTH;
        return PTR_W'(s);
    endfunction

    ternary_pc_incr #(.PC_TRITS(PC_TRITS)) u_pc_adv (
        .pc      (fetch_pc),
        .inc     (push_n),
        .pc_next (pc_adv)
    );

    ternary_pc_incr #(.PC_TRITS(PC_TRITS)) u_pc_p1 (
        .pc      (fetch_pc),
        .inc     (2'd1),
        .pc_next (fetch_pc_p1)
    );

    always_comb begin
`ifdef TERNARY_FETCH_BYPASS_EN
        bypass = (occ == '0) && !redirect_valid;
`else
        bypass = 1'b0;
`endif
        deq_eff = (deq_count == 2'd3) ? 2'd2 : deq_count;
        pop_n   = (int'(deq_eff) > int'(occ)) ? 2'(occ) : deq_eff;
        free    = QUEUE_DEPTH - int'(occ) + int'(pop_n);
        if (!fetch_en)
            push_n = 2'd0;
        else if (free >= 2)
            push_n = 2'd2;
        else if (free == 1)
            push_n = 2'd1;
        else
            push_n = 2'd0;

        // In bypass the queue is empty (pop_n is 0); issue may consume the
        // forwarded slots directly, and only the leftovers are stored.
        wr_n    = push_n;
        src_ofs = 2'd0;
        if (bypass) begin
            src_ofs = (deq_eff < push_n) ? deq_eff : push_n;
            wr_n    = push_n - src_ofs;
        end

        occ_next  = occ + OCC_W'(wr_n) - OCC_W'(pop_n);
        head_next = ptr_add(head, int'(pop_n));
        tail_next = ptr_add(tail, int'(wr_n));
        tail_p1   = ptr_add(tail, 1);
        head_p1   = ptr_add(head, 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= {PC_TRITS{T_ZERO}};
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            fetch_pc <= pc_adv;
            head     <= head_next;
            tail     <= tail_next;
            occ      <= occ_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by occ.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (wr_n != 2'd0) begin
                mem_instr[tail] <= (src_ofs == 2'd0) ? imem_data[8:0] : imem_data[17:9];
                mem_pc[tail]    <= (src_ofs == 2'd0) ? fetch_pc : fetch_pc_p1;
            end
            if (wr_n == 2'd2) begin
                mem_instr[tail_p1] <= imem_data[17:9];
                mem_pc[tail_p1]    <= fetch_pc_p1;
            end
        end
    end

    always_comb begin
        logic v0;
        logic v1;
        v0        = (occ >= OCC_W'(1));
        v1        = (occ >= OCC_W'(2));
        out_valid = {v1, v0};
        out_instr = {TRIT9_ZERO, TRIT9_ZERO};
        out_pc    = {PC_TRITS{T_ZERO}};
        if (v0) begin
            out_instr[8:0] = mem_instr[head];
            out_pc         = mem_pc[head];
        end
        if (v1)
            out_instr[17:9] = mem_instr[head_p1];
`ifdef TERNARY_FETCH_BYPASS_EN
        if (bypass) begin
            out_valid = {push_n == 2'd2, push_n != 2'd0};
            out_instr = {TRIT9_ZERO, TRIT9_ZERO};
            if (push_n != 2'd0)
                out_instr[8:0] = imem_data[8:0];
            if (push_n == 2'd2)
                out_instr[17:9] = imem_data[17:9];
            out_pc = fetch_pc;
        end
`endif
    end

    assign imem_addr = fetch_pc;
    assign occupancy = occ;

endmodule

// File: doc/ternary_fetch_queue.md
TERNARY_FETCH_QUEUE -- requirements
Module: ternary_fetch_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction-queue entries (legal ≥2).
REQ-002 SHALL have parameter PC_TRITS, default 8, fetch PC width in trits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port fetch_en  input  1  permits new fetches when high.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  trit_t[PC_TRITS-1:0]  redirect target.
REQ-008 SHALL have port imem_addr  output  trit_t[PC_TRITS-1:0]  fetch PC to combinational-read instruction memory.
REQ-009 SHALL have port imem_data  input  trit_t[17:0]  [8:0]=instr at fetch PC, [17:9]=instr at fetch PC+1.
REQ-010 SHALL have port deq_count  input  2  instructions consumed by issue this cycle (0..2).
REQ-011 SHALL have port out_valid  output  2  bit0 head valid, bit1 head+1 valid.
REQ-012 SHALL have port out_instr  output  trit_t[17:0]  [8:0]=head, [17:9]=head+1.
REQ-013 SHALL have port out_pc  output  trit_t[PC_TRITS-1:0]  PC of head.
REQ-014 SHALL have port occupancy  output  $clog2(QUEUE_DEPTH+1)  valid entries.

Function
REQ-015 imem_addr SHALL equal fetch PC register combinationally.
REQ-016 Effective pop = min(deq_count, occupancy); deq_count of 3 SHALL be treated as 2.
REQ-017 free = QUEUE_DEPTH - occupancy + pop; push 2 (slots A,B) if free≥2, push 1 (slot A only) if free==1, else 0; push forced 0 when fetch_en low.
REQ-018 Fetch PC SHALL advance by push count using balanced-ternary addition, modulo 3^PC_TRITS (max positive +1 wraps to most negative).
REQ-019 Each entry SHALL store instruction and its PC; entry PCs SHALL be consecutive fetch PCs.
REQ-020 Push and pop in the same cycle SHALL both take effect; occupancy_next = occupancy + push - pop.
REQ-021 Outputs SHALL reflect queue head registers; out_valid bits SHALL be 0 for empty slots, out_instr of invalid slots SHALL be TRIT9_ZERO.
REQ-022 Latency (bypass off): instruction at PC P visible on out_instr one cycle after imem_addr==P.
REQ-023 redirect_valid SHALL, at next edge: empty queue, set fetch PC=redirect_pc, discard that cycle's push and pop; redirect has priority over everything except rst.
REQ-024 Block SHALL not check IMEM bounds; out-of-range fetches are queued as returned (NOP).

Reset
REQ-025 rst SHALL set fetch PC to all T_ZERO, occupancy 0, pointers 0, out_valid 2'b00, out_instr TRIT9_ZERO pair, out_pc zero.
REQ-026 rst mid-operation SHALL override redirect, push and pop in that cycle.

Configuration
REQ-027 With TERNARY_FETCH_BYPASS_EN defined, when occupancy==0 and no redirect, imem_data SHALL drive out_instr/out_valid (per push count) and out_pc=fetch PC same cycle; popped bypassed entries SHALL not be written.
REQ-028 Without TERNARY_FETCH_BYPASS_EN, outputs SHALL come from queue registers only (REQ-022 latency).

Structure
REQ-029 trit_t, TRIT9_ZERO, T_* constants and a balanced-ternary add helper SHALL come from ternary_pkg.
REQ-030 PC advance SHALL be sub-module ternary_pc_incr (PC_TRITS-wide, increment 0/1/2, wrap-around).
REQ-031 Queue SHALL be circular buffer with modulo-QUEUE_DEPTH head/tail pointers.

Verification
REQ-032 Reset, fetch_en=1, deq_count=0: imem_addr 0,2,4 then holds 4; occupancy 2,4,4; out_pc=0.
REQ-033 Full queue, deq_count=2 each cycle: push 2/cycle, occupancy stays 4, out_pc steps +2.
REQ-034 Occupancy 3, deq_count=0: push 1 (slot A only), fetch PC +1, occupancy 4.
REQ-035 redirect_valid with redirect_pc=-5 and deq_count=2: next cycle occupancy 0, imem_addr=-5, out_valid=0.
REQ-036 Fetch PC=+3280 (8 trits), push 2: next fetch PC=-3279.
REQ-037 TERNARY_FETCH_BYPASS_EN defined, empty queue, imem_data={I1,I0}: same cycle out_valid=2'b11, out_instr={I1,I0}.
